// File: rtl/conv1d_pkg.sv
// Shared types and constants for the 1-D convolution front end and its conv unit.
package conv1d_pkg;

  typedef enum logic [1:0] {FILL, START, RUN, OUT} feeder_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_F          = 64;

  // Conv unit needs one cycle per tap plus four pipeline cycles before its result is final.
  function automatic int conv_latency(input int f);
    return f + 4;
  endfunction

endpackage

// File: rtl/window_shift_reg.sv
// F-deep sample shift register; element 0 is the oldest sample, element F-1 the newest.
module window_shift_reg #(
  parameter int DATA_WIDTH = 16,
  parameter int F          = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    shift_en,
  input  logic                    clear,
  input  logic [DATA_WIDTH-1:0]   shift_in,
  output logic [0:F*DATA_WIDTH-1] window
);

  logic [DATA_WIDTH-1:0] elem [F];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < F; k++) elem[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < F; k++) elem[k] <= '0;
    end else if (shift_en) begin
      for (int k = 0; k < F-1; k++) elem[k] <= elem[k+1];
      elem[F-1] <= shift_in;
    end
  end

  for (genvar k = 0; k < F; k++) begin : g_flat
    assign window[k*DATA_WIDTH +: DATA_WIDTH] = elem[k];
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Builds sliding sample windows, sequences one conv-unit run per window and returns its result.
module conv_window_feeder
  import conv1d_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int F            = DEF_F,
  parameter int STRIDE       = 1,
  parameter int CONV_LATENCY = conv_latency(F)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_last,
  output logic [0:F*DATA_WIDTH-1] window,
  output logic                    conv_rst_n,
  input  logic [DATA_WIDTH-1:0]   conv_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_last
);

  localparam int FW = $clog2(F + 1);
  localparam int CW = $clog2(CONV_LATENCY + 1);
  localparam logic [FW-1:0] F_CNT      = FW'(F);
  localparam logic [FW-1:0] STRIDE_CNT = FW'(STRIDE);
  localparam logic [FW-1:0] ONE_F      = FW'(1);
  localparam logic [CW-1:0] RUN_LAST   = CW'(CONV_LATENCY - 1);
  localparam logic [CW-1:0] ONE_C      = CW'(1);

  feeder_state_e state;
  logic [FW-1:0] fill;
  logic [FW-1:0] need;
  logic [CW-1:0] cnt;
  logic          last_pend;
  logic          accept;
  logic          completes;
  logic          discard;

  // in_ready is only ever high in FILL, so accept implies FILL.
  assign accept    = in_valid && in_ready;
  assign completes = accept && (need == ONE_F);
  assign discard   = accept && in_last && !completes;

  window_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH),
    .F         (F)
  ) u_window (
    .clk     (clk),
    .reset   (reset),
    .shift_en(accept),
    .clear   (discard),
    .shift_in(in_data),
    .window  (window)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= FILL;
      fill       <= '0;
      need       <= F_CNT;
      cnt        <= '0;
      last_pend  <= 1'b0;
      in_ready   <= 1'b0;
      conv_rst_n <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (fill != F_CNT) fill <= fill + ONE_F;
            if (completes) begin
              need      <= '0;
              last_pend <= in_last;
              in_ready  <= 1'b0;
              state     <= START;
            end else if (in_last) begin
              // Frame ended before a full window: drop the partial window.
              fill <= '0;
              need <= F_CNT;
            end else begin
              need <= need - ONE_F;
            end
          end
        end
        START: begin
          cnt        <= RUN_LAST;
          conv_rst_n <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (cnt == '0) begin
            out_data   <= conv_result;
            out_last   <= last_pend;
            out_valid  <= 1'b1;
            conv_rst_n <= 1'b0;
            state      <= OUT;
          end else begin
            cnt <= cnt - ONE_C;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= FILL;
            if (last_pend) begin
              fill <= '0;
              need <= F_CNT;
            end else begin
              need <= STRIDE_CNT;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  stride_legal: assert property (@(posedge clk) disable iff (!reset)
                                 (STRIDE >= 1 && STRIDE <= F));

endmodule
